// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Memory-stage load/store unit. It takes one valid load or store from the
// EX/MEM register and runs it as a single req/ack transaction on the data bus.
// Store data is lane-replicated and byte-masked. Load data is lane-selected
// and then sign- or zero-extended. The pipeline is stalled while the access is
// in flight. Misaligned accesses are rejected without a bus request.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a REQ that gets no ack
// within TIMEOUT_CYCLES cycles (o_bus_err pulse). When it is not defined, REQ
// waits for ack indefinitely and o_bus_err is tied low.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), synchronous active-high reset
//   i_insn_vld            MEM-stage instruction valid
//   i_mem_wren/_rden      store / load request (both set -> store)
//   i_sl_sel[2:0]         000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr, i_st_data     byte address, store operand
//   o_stall               freeze upstream pipeline registers
//   o_dmem_*              data bus request, write enable, word address,
//                         byte enables and write data
//   i_dmem_ack/_rdata     bus accept and read word (valid with ack)
//   o_ld_data, o_ld_vld   extended load result, one-cycle valid pulse
//   o_misalign            one-cycle pulse, misaligned access rejected
//   o_bus_err             one-cycle pulse, bus timeout
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic        i_mem_wren,
    input  logic        i_mem_rden,
    input  logic [2:0]  i_sl_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_misalign,
    output logic        o_bus_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
        $error("lsu_mem_stage: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [29:0] waddr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  sl_sel_q;
    logic [1:0]  off_q;
    logic [31:0] ld_data_q;
    logic        ld_vld_q;
    logic        misalign_q;

    logic        start;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_lane;
    logic [31:0] ld_ext;

    assign start = i_insn_vld & (i_mem_rden | i_mem_wren);

    // Size is sl_sel[1:0]; bit 2 only selects zero-extension for loads.
    assign misaligned = ((i_sl_sel[1:0] == 2'b01) & i_addr[0]) |
                        (i_sl_sel[1] & (i_addr[1:0] != 2'b00));

    // Store lane alignment: replicate the operand into every lane and let the
    // byte enables pick the addressed one(s).
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_st_data;
        case (i_sl_sel[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {i_addr[1], 1'b0};
                st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = i_st_data;
            end
        endcase
    end

    // Load lane select and extension, using the offset captured at start.
    assign ld_lane = i_dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_lane;
        case (sl_sel_q[1:0])
            2'b00: ld_ext = sl_sel_q[2] ? {24'h000000, ld_lane[7:0]}
                                        : {{24{ld_lane[7]}}, ld_lane[7:0]};
            2'b01: ld_ext = sl_sel_q[2] ? {16'h0000, ld_lane[15:0]}
                                        : {{16{ld_lane[15]}}, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       bus_err_q;

    // tmo_cnt_q counts completed ack-less REQ cycles, so the REQ cycle in
    // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign timeout_hit = (state_q == StReq) && !i_dmem_ack && (tmo_cnt_q == TmoLimit);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt_q <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            // Held at zero outside REQ, so it is clear on every REQ entry.
            if (state_q != StReq) begin
                tmo_cnt_q <= 8'd0;
            end else if (!i_dmem_ack) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    assign o_bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign o_bus_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= 30'd0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'd0;
            sl_sel_q   <= 3'b000;
            off_q      <= 2'b00;
            ld_data_q  <= 32'd0;
            ld_vld_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            ld_vld_q   <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    misalign_q <= start & misaligned;
                    if (start && !misaligned) begin
                        req_q    <= 1'b1;
                        we_q     <= i_mem_wren;
                        waddr_q  <= i_addr[31:2];
                        be_q     <= st_be;
                        wdata_q  <= st_wdata;
                        sl_sel_q <= i_sl_sel;
                        off_q    <= i_addr[1:0];
                        state_q  <= StReq;
                    end
                end
                StReq: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (i_dmem_ack) begin
                        if (!we_q) begin
                            ld_data_q <= ld_ext;
                            ld_vld_q  <= 1'b1;
                        end
                        req_q   <= 1'b0;
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        ld_data_q <= 32'd0;
                        req_q     <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The stall must rise in the start cycle itself, hence the IDLE term.
    assign o_stall      = ((state_q == StIdle) & start & ~misaligned) | req_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {waddr_q, 2'b00};
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_ld_data    = ld_data_q;
    assign o_ld_vld     = ld_vld_q;
    assign o_misalign   = misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_insn_vld;
    logic        i_mem_wren;
    logic        i_mem_rden;
    logic [2:0]  i_sl_sel;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_ld_data;
    logic        o_ld_vld;
    logic        o_misalign;
    logic        o_bus_err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ldvld  = 0;
    int n_err    = 0;
    logic [31:0] exp_ld_q[$];

    always #5 i_clk = ~i_clk;

    lsu_mem_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_insn_vld  (i_insn_vld),
        .i_mem_wren  (i_mem_wren),
        .i_mem_rden  (i_mem_rden),
        .i_sl_sel    (i_sl_sel),
        .i_addr      (i_addr),
        .i_st_data   (i_st_data),
        .o_stall     (o_stall),
        .o_dmem_req  (o_dmem_req),
        .o_dmem_we   (o_dmem_we),
        .o_dmem_addr (o_dmem_addr),
        .o_dmem_be   (o_dmem_be),
        .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack  (i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata),
        .o_ld_data   (o_ld_data),
        .o_ld_vld    (o_ld_vld),
        .o_misalign  (o_misalign),
        .o_bus_err   (o_bus_err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_ld_vld === 1'b1) n_ldvld++;
        if (o_bus_err === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic wr, input logic rd,
                         input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] sd);
        i_insn_vld = vld;
        i_mem_wren = wr;
        i_mem_rden = rd;
        i_sl_sel   = sel;
        i_addr     = addr;
        i_st_data  = sd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = $urandom;
    endtask

    // One aligned access: the instruction is held through DONE, ack is given
    // in REQ cycle wait_n+1. Expected bus fields and load result are constants.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] sel,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int wait_n, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                             input int exp_stall);
        int stall_n;
        step();
        drive(1'b1, wr, ~wr, sel, addr, sd);
        if (!wr) exp_ld_q.push_back(exp_ld);
        #1;
        stall_n = int'(o_stall);
        chk({tag, "_idle_req"}, o_dmem_req, 1'b0);
        for (int n = 0; n <= wait_n; n++) begin
            step();
            if (n == wait_n) begin
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = rdata;
            end
            #1;
            stall_n += int'(o_stall);
            if (n == 0 || n == wait_n) begin
                chk({tag, "_req"}, o_dmem_req, 1'b1);
                chk({tag, "_we"}, o_dmem_we, wr);
                chk({tag, "_addr"}, o_dmem_addr, exp_addr);
                chk({tag, "_be"}, o_dmem_be, exp_be);
                if (wr) chk({tag, "_wdata"}, o_dmem_wdata, exp_wdata);
            end
        end
        step();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = $urandom;
        #1;
        stall_n += int'(o_stall);
        chk({tag, "_done_req"}, o_dmem_req, 1'b0);
        chk({tag, "_ld_vld"}, o_ld_vld, !wr);
        if (o_ld_vld === 1'b1 && exp_ld_q.size() > 0) begin
            chk({tag, "_ld_data"}, o_ld_data, exp_ld_q.pop_front());
        end
        chk({tag, "_stall_cycles"}, stall_n, exp_stall);
        step();
        idle_inputs();
    endtask

    // Misaligned access: no request, no stall, misalign pulse next cycle.
    task automatic do_misalign(input string tag, input logic wr, input logic [2:0] sel,
                               input logic [31:0] addr);
        step();
        drive(1'b1, wr, ~wr, sel, addr, 32'h1234_5678);
        #1;
        chk({tag, "_stall"}, o_stall, 1'b0);
        step();
        idle_inputs();
        #1;
        chk({tag, "_pulse"}, o_misalign, 1'b1);
        chk({tag, "_noreq"}, o_dmem_req, 1'b0);
        step();
        #1;
        chk({tag, "_pulse_end"}, o_misalign, 1'b0);
    endtask

    initial begin
        int base_vld;
        int base_err;
        idle_inputs();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        #1;
        chk("rst_req", o_dmem_req, 1'b0);
        chk("rst_we", o_dmem_we, 1'b0);
        chk("rst_addr", o_dmem_addr, 32'h0);
        chk("rst_be", o_dmem_be, 4'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);
        chk("rst_ld_data", o_ld_data, 32'h0);
        chk("rst_flags", {o_stall, o_ld_vld, o_misalign, o_bus_err}, 4'h0);

        do_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF,
                  32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2);
        do_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h8011_2233,
                  32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 5);
        do_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h8011_2233,
                  32'h100, 4'b1000, 32'h0, 32'h0000_0080, 5);
        do_access("lh", 1'b0, 3'b001, 32'h042, 32'h0, 1, 32'h9ABC_1234,
                  32'h040, 4'b1100, 32'h0, 32'hFFFF_9ABC, 3);
        do_access("lhu", 1'b0, 3'b101, 32'h040, 32'h0, 0, 32'h1234_F00D,
                  32'h040, 4'b0011, 32'h0, 32'h0000_F00D, 2);
        base_vld = n_ldvld;
        do_access("sh", 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1, 32'h0,
                  32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 3);
        do_access("sb", 1'b1, 3'b000, 32'h301, 32'hFFFF_FF5A, 0, 32'h0,
                  32'h300, 4'b0010, 32'h5A5A_5A5A, 32'h0, 2);
        do_access("sw", 1'b1, 3'b010, 32'h404, 32'hCAFE_F00D, 2, 32'h0,
                  32'h404, 4'b1111, 32'hCAFE_F00D, 32'h0, 4);
        chk("store_no_ldvld", n_ldvld, base_vld);
        chk("store_ld_data_held", o_ld_data, 32'h0000_F00D);

        // Both enables set: treated as a store.
        do_access("both_en", 1'b1, 3'b010, 32'h500, 32'h0102_0304, 0, 32'h0,
                  32'h500, 4'b1111, 32'h0102_0304, 32'h0, 2);

        do_misalign("mis_lw", 1'b0, 3'b010, 32'h101);
        do_misalign("mis_sh", 1'b1, 3'b001, 32'h203);

        // Flushed bubble: rden with insn_vld low.
        step();
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
        #1;
        chk("bubble_stall", o_stall, 1'b0);
        step();
        #1;
        chk("bubble_req", o_dmem_req, 1'b0);
        idle_inputs();

        // Spurious ack in IDLE.
        base_vld = n_ldvld;
        step();
        i_dmem_ack = 1'b1;
        step();
        i_dmem_ack = 1'b0;
        step();
        #1;
        chk("spurious_ack_vld", n_ldvld, base_vld);
        chk("spurious_ack_req", o_dmem_req, 1'b0);

        // Reset during REQ aborts without pulses.
        base_vld = n_ldvld;
        base_err = n_err;
        step();
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
        step();
        #1;
        chk("abort_req_up", o_dmem_req, 1'b1);
        i_reset = 1'b1;
        idle_inputs();
        step();
        i_reset = 1'b0;
        #1;
        chk("abort_req", o_dmem_req, 1'b0);
        chk("abort_stall", o_stall, 1'b0);
        step();
        step();
        #1;
        chk("abort_no_vld", n_ldvld, base_vld);
        chk("abort_no_err", n_err, base_err);
        // Back in IDLE: a fresh access must run normally.
        do_access("post_rst", 1'b0, 3'b010, 32'h600, 32'h0, 0, 32'h1357_9BDF,
                  32'h600, 4'b1111, 32'h0, 32'h1357_9BDF, 2);

        // Ack on the 4th REQ cycle completes normally.
        base_err = n_err;
        do_access("ack_at_limit", 1'b0, 3'b010, 32'h700, 32'h0, 3, 32'h2468_ACE0,
                  32'h700, 4'b1111, 32'h0, 32'h2468_ACE0, 5);
        chk("ack_at_limit_no_err", n_err, base_err);

`ifdef LSU_TIMEOUT_EN
        step();
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h800, 32'h0);
        for (int n = 0; n < 4; n++) begin
            step();
            #1;
            chk("tmo_req", o_dmem_req, 1'b1);
        end
        step();
        #1;
        chk("tmo_err", o_bus_err, 1'b1);
        chk("tmo_ld_data", o_ld_data, 32'h0);
        chk("tmo_ld_vld", o_ld_vld, 1'b0);
        chk("tmo_stall", o_stall, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("tmo_err_end", o_bus_err, 1'b0);
`else
        // Without the timeout REQ waits for ack indefinitely.
        step();
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h802, 32'h0);
        exp_ld_q.push_back(32'h0000_007F);
        for (int n = 0; n < 20; n++) step();
        #1;
        chk("notmo_req", o_dmem_req, 1'b1);
        chk("notmo_stall", o_stall, 1'b1);
        chk("notmo_err", n_err, 0);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h017F_0000;
        step();
        i_dmem_ack = 1'b0;
        #1;
        chk("notmo_vld", o_ld_vld, 1'b1);
        if (o_ld_vld === 1'b1 && exp_ld_q.size() > 0) begin
            chk("notmo_ld_data", o_ld_data, exp_ld_q.pop_front());
        end
        step();
        idle_inputs();
`endif

        step();
        chk("sb_empty", exp_ld_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
